// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - SS.hh BCD stopwatch with start/stop, clear and lap-freeze display
module bcd_stopwatch #(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       running,
  output logic       frozen,
  output logic       wrap
);

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    s1, s0, h1, h0;
  logic [3:0]    s1_n, s0_n, h1_n, h0_n;
  logic [3:0]    d3_n, d2_n, d1_n, d0_n;
  logic          frozen_n, wrap_n, tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      {s1, s0, h1, h0} <= '0;
      {dig3, dig2, dig1, dig0} <= '0;
      running <= 1'b0;
      frozen  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      {s1, s0, h1, h0} <= {s1_n, s0_n, h1_n, h0_n};
      {dig3, dig2, dig1, dig0} <= {d3_n, d2_n, d1_n, d0_n};
      running <= (state_n == RUN);
      frozen  <= frozen_n;
      wrap    <= wrap_n;
    end
  end

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    {s1_n, s0_n, h1_n, h0_n} = {s1, s0, h1, h0};
    {d3_n, d2_n, d1_n, d0_n} = {dig3, dig2, dig1, dig0};
    frozen_n = frozen;
    wrap_n   = 1'b0;
    tick     = (state == RUN) && (presc == PW'(DIV - 1));

    if (clear) begin
      state_n  = IDLE;
      presc_n  = '0;
      {s1_n, s0_n, h1_n, h0_n} = '0;
      {d3_n, d2_n, d1_n, d0_n} = '0;
      frozen_n = 1'b0;
    end else begin
      case (state)
        IDLE:    if (start_stop) state_n = RUN;
        RUN:     if (start_stop) state_n = PAUSE;
        PAUSE:   if (start_stop) state_n = RUN;
        default: state_n = IDLE;
      endcase

      if (state == RUN) presc_n = tick ? '0 : presc + PW'(1);

      // Ripple carry: each digit rolls over only when all lower digits roll over.
      if (tick) begin
        if (h0 != 4'd9) h0_n = h0 + 4'd1;
        else begin
          h0_n = 4'd0;
          if (h1 != 4'd9) h1_n = h1 + 4'd1;
          else begin
            h1_n = 4'd0;
            if (s0 != 4'd9) s0_n = s0 + 4'd1;
            else begin
              s0_n = 4'd0;
              if (s1 != 4'd5) s1_n = s1 + 4'd1;
              else begin
                s1_n   = 4'd0;
                wrap_n = 1'b1;
              end
            end
          end
        end
      end

      if (lap) begin
        if (state == RUN) frozen_n = ~frozen;
        else if (state == PAUSE && frozen) frozen_n = 1'b0;
      end

      // Display tracks the next live value unless it stays frozen across this edge.
      if (!(frozen && frozen_n)) {d3_n, d2_n, d1_n, d0_n} = {s1_n, s0_n, h1_n, h0_n};
    end
  end

endmodule
